led_fader: RTL and testbench

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 116 +++++++++++
 tb/tb_led_fader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// Multi-channel LED fader: accepts an on/off pattern, then ramps every channel's
// PWM brightness one step per prescaler tick towards its target endpoint.
module led_fader #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 390625
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                pattern_valid,
    output logic                pattern_ready,
    output logic                busy,
    output logic [NUM_LEDS-1:0] leds
);
    localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;

    typedef enum logic {S_IDLE, S_FADE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_ready;
    logic [PRE_W-1:0]     r_presc;
    logic [PRE_W-1:0]     w_presc_next;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic [NUM_LEDS-1:0]  r_target;
    logic [NUM_LEDS-1:0]  w_target_next;
    logic [NUM_LEDS-1:0]  w_at_end;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_all_done;

    assign w_accept      = pattern_valid && r_ready;
    assign w_tick        = (r_state == S_FADE) && (r_presc == PRE_LAST);
    assign w_all_done    = &w_at_end;
    assign pattern_ready = r_ready;
    assign busy          = ~r_ready;

    always_comb begin
        w_state_next  = r_state;
        w_presc_next  = r_presc;
        w_target_next = r_target;
        case (r_state)
            S_IDLE: begin
                w_presc_next = '0;
                if (w_accept) begin
                    w_target_next = pattern_in;
                    w_state_next  = S_FADE;
                end
            end
            S_FADE: begin
                w_presc_next = w_tick ? '0 : r_presc + 1'b1;
                // Leave only once every channel lands on its endpoint on this tick.
                if (w_tick && w_all_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_presc_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_presc   <= '0;
            r_target  <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ready   <= (w_state_next == S_IDLE);
            r_presc   <= w_presc_next;
            r_target  <= w_target_next;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            logic [PWM_BITS-1:0] r_level;
            logic [PWM_BITS-1:0] w_level_step;
            logic                r_led;

            // Saturating step towards the target endpoint; never wraps.
            always_comb begin
                w_level_step = r_level;
                if (r_target[gi] && (r_level != LVL_MAX)) begin
                    w_level_step = r_level + 1'b1;
                end else if (!r_target[gi] && (r_level != '0)) begin
                    w_level_step = r_level - 1'b1;
                end
            end

            assign w_at_end[gi] = r_target[gi] ? (w_level_step == LVL_MAX)
                                               : (w_level_step == '0);
            assign leds[gi]     = r_led;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_level <= '0;
                    r_led   <= 1'b0;
                end else begin
                    if (w_tick) begin
                        r_level <= w_level_step;
                    end
                    r_led <= (r_level > r_pwm_cnt);
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_led_fader.sv
// Scoreboard-driven bench for led_fader with a short step divider so whole fades
// complete in about a thousand cycles.
module tb_led_fader;
    localparam int NUM_LEDS = 4;
    localparam int PWM_BITS = 8;
    localparam int STEP_DIV = 4;

    logic                clk = 1'b0;
    logic                clk_en = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_LEDS-1:0] pattern_in = '0;
    logic                pattern_valid = 1'b0;
    logic                pattern_ready;
    logic                busy;
    logic [NUM_LEDS-1:0] leds;

    typedef struct {
        string  name;
        integer exp;
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    integer obs;
    int     n_checks = 0;
    int     n_fail = 0;
    int     duty[NUM_LEDS];
    int     n;
    logic [PWM_BITS-1:0] pwm_m;

    led_fader #(
        .NUM_LEDS(NUM_LEDS),
        .PWM_BITS(PWM_BITS),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pattern_in   (pattern_in),
        .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready),
        .busy         (busy),
        .leds         (leds)
    );

    always #5 if (clk_en) clk = ~clk;

    // Free-running PWM phase reference, used only to align stimulus.
    always @(posedge clk or negedge rst) begin
        if (!rst) pwm_m <= '0;
        else      pwm_m <= pwm_m + 8'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (pattern_ready === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) duty[i] = 0;
        repeat (256) begin
            step();
            for (int i = 0; i < NUM_LEDS; i++) if (leds[i] === 1'b1) duty[i]++;
        end
    endtask

    task automatic send(input logic [NUM_LEDS-1:0] p);
        pattern_in    = p;
        pattern_valid = 1'b1;
        step();
        pattern_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sb.push_back('{"reset_leds", 0});
        sb.push_back('{"reset_ready", 1});
        sb.push_back('{"reset_busy", 0});
        #1;
        e = sb.pop_front(); obs = leds; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        e = sb.pop_front(); obs = pattern_ready; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        e = sb.pop_front(); obs = busy; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        $display("reset: leds=%b ready=%b busy=%b", leds, pattern_ready, busy);
        #5;
        rst = 1'b1;
        #2;
        clk_en = 1'b1;
        repeat (3) step();
    endtask

    // Fade up to 0101 while 1111 is held valid; 1111 must wait for IDLE.
    task automatic test_fade_up_busy();
        int l1 = 0;
        pattern_in    = 4'b0101;
        pattern_valid = 1'b1;
        sb.push_back('{"fu_ready_after_accept", 0});
        sb.push_back('{"fu_busy_after_accept", 1});
        sb.push_back('{"fu_cycles_to_ready", 1020});
        sb.push_back('{"fu_led1_high_during_fade", 0});
        step();
        pattern_in = 4'b1111;
        e = sb.pop_front(); obs = pattern_ready; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        e = sb.pop_front(); obs = busy; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        n = -1;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (leds[1] !== 1'b0) l1++;
            if (pattern_ready === 1'b1) begin
                n = i;
                break;
            end
        end
        e = sb.pop_front(); obs = n; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        e = sb.pop_front(); obs = l1; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        $display("fade_up 0101: ready after %0d cycles, led1 high %0d cycles", n, l1);

        sb.push_back('{"held_1111_accepted_in_idle", 0});
        step();
        pattern_valid = 1'b0;
        e = sb.pop_front(); obs = pattern_ready; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        sb.push_back('{"fu1111_cycles_to_ready", 1020});
        for (int i = 0; i < NUM_LEDS; i++) sb.push_back('{$sformatf("fu1111_duty%0d", i), 255});
        wait_ready(1100, n);
        e = sb.pop_front(); obs = n; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) begin
            e = sb.pop_front(); obs = duty[i]; n_checks++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        end
        $display("fade_up 1111: ready after %0d cycles, duty %0d %0d %0d %0d", n, duty[0], duty[1], duty[2], duty[3]);

        sb.push_back('{"to0101_cycles_to_ready", 1020});
        sb.push_back('{"steady0101_duty0", 255});
        sb.push_back('{"steady0101_duty1", 0});
        sb.push_back('{"steady0101_duty2", 255});
        sb.push_back('{"steady0101_duty3", 0});
        send(4'b0101);
        wait_ready(1100, n);
        e = sb.pop_front(); obs = n; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) begin
            e = sb.pop_front(); obs = duty[i]; n_checks++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        end
        $display("to 0101: ready after %0d cycles, duty %0d %0d %0d %0d", n, duty[0], duty[1], duty[2], duty[3]);
    endtask

    task automatic test_no_change();
        sb.push_back('{"nochange_cycles_to_ready", STEP_DIV});
        sb.push_back('{"nochange_duty0", 255});
        sb.push_back('{"nochange_duty1", 0});
        sb.push_back('{"nochange_duty2", 255});
        sb.push_back('{"nochange_duty3", 0});
        send(4'b0101);
        wait_ready(20, n);
        e = sb.pop_front(); obs = n; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) begin
            e = sb.pop_front(); obs = duty[i]; n_checks++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        end
        $display("no_change: ready after %0d cycles, duty %0d %0d %0d %0d", n, duty[0], duty[1], duty[2], duty[3]);
    endtask

    // Aligned so the PWM counter sweeps 126..129 while level[0] sits at 128.
    task automatic test_fade_down();
        while (pwm_m !== 8'd129) step();
        sb.push_back('{"fd_lvl128_pwm126", 1});
        sb.push_back('{"fd_lvl128_pwm127", 1});
        sb.push_back('{"fd_lvl128_pwm128", 0});
        sb.push_back('{"fd_lvl128_pwm129", 0});
        send(4'b0000);
        repeat (127 * STEP_DIV) step();
        for (int k = 0; k < 4; k++) begin
            step();
            e = sb.pop_front(); obs = leds[0]; n_checks++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        end
        sb.push_back('{"fd_cycles_to_ready", 1020 - 128 * STEP_DIV});
        for (int i = 0; i < NUM_LEDS; i++) sb.push_back('{$sformatf("fd_duty%0d", i), 0});
        sb.push_back('{"fd_ready_steady", 1});
        wait_ready(700, n);
        e = sb.pop_front(); obs = n; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) begin
            e = sb.pop_front(); obs = duty[i]; n_checks++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        end
        e = sb.pop_front(); obs = pattern_ready; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        $display("fade_down: ready after %0d more cycles, duty %0d %0d %0d %0d", n, duty[0], duty[1], duty[2], duty[3]);
    endtask

    task automatic test_reset_mid_fade();
        send(4'b1111);
        repeat (100 * STEP_DIV) step();
        sb.push_back('{"midrst_leds", 0});
        sb.push_back('{"midrst_ready", 1});
        sb.push_back('{"midrst_busy", 0});
        #2;
        rst = 1'b0;
        #1;
        e = sb.pop_front(); obs = leds; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        e = sb.pop_front(); obs = pattern_ready; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        e = sb.pop_front(); obs = busy; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        pattern_in    = 4'b0000;
        pattern_valid = 1'b1;
        sb.push_back('{"midrst_first_edge_accept", 0});
        sb.push_back('{"midrst_cycles_to_ready", STEP_DIV});
        for (int i = 0; i < NUM_LEDS; i++) sb.push_back('{$sformatf("midrst_duty%0d", i), 0});
        #2;
        rst = 1'b1;
        step();
        pattern_valid = 1'b0;
        e = sb.pop_front(); obs = pattern_ready; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        wait_ready(20, n);
        e = sb.pop_front(); obs = n; n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) begin
            e = sb.pop_front(); obs = duty[i]; n_checks++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, obs, e.exp); end
        end
        $display("reset_mid_fade: ready after %0d cycles, duty %0d %0d %0d %0d", n, duty[0], duty[1], duty[2], duty[3]);
    endtask

    initial begin
        test_reset();
        test_fade_up_busy();
        test_no_change();
        test_fade_down();
        test_reset_mid_fade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
